// File: rtl/btn_input_ctrl.sv
// Push-button input peripheral: 2-flop sync, per-button debounce, sticky press flags, press counter.
// Optional BTN_RELEASE_EVT_EN adds sticky release flags in the upper half of the EVENT word.
module btn_input_ctrl #(
  parameter int N_BTN           = 5,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button,
  input  logic [11:0]      addr,
  input  logic             wen,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [N_BTN-1:0] btn_stable
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] SEL_LEVEL = 2'd0;
  localparam logic [1:0] SEL_EVENT = 2'd1;
  localparam logic [1:0] SEL_COUNT = 2'd2;

  logic [N_BTN-1:0] s0;
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] evt;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [15:0]      press_cnt;

  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [15:0]      rise_cnt;
  logic [1:0]       sel;
  logic             wr_evt;
  logic             wr_cnt;
  logic [N_BTN-1:0] evt_clr;

  assign sel    = addr[3:2];
  assign wr_evt = wen && (sel == SEL_EVENT);
  assign wr_cnt = wen && (sel == SEL_COUNT);
  assign evt_clr = wr_evt ? wdata[N_BTN-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= button;
      s1 <= s0;
    end
  end

  // A button's stable level flips on the edge where its count reaches the terminal value.
  always_comb begin
    accept   = '0;
    rise_cnt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (s1[i] != stable[i]) && (cnt[i] == TC);
      rise_cnt  = rise_cnt + 16'(accept[i] & s1[i]);
    end
  end

  assign rise = accept & s1;
  assign fall = accept & ~s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      stable <= stable ^ accept;
      for (int i = 0; i < N_BTN; i++) begin
        if ((s1[i] == stable[i]) || accept[i]) cnt[i] <= '0;
        else                                   cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // New presses win over a same-edge clear, for both the flags and the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt       <= '0;
      press_cnt <= '0;
    end else begin
      evt       <= (evt & ~evt_clr) | rise;
      press_cnt <= (wr_cnt ? 16'd0 : press_cnt) + rise_cnt;
    end
  end

`ifdef BTN_RELEASE_EVT_EN
  logic [N_BTN-1:0] rel;
  logic [N_BTN-1:0] rel_clr;

  assign rel_clr = wr_evt ? wdata[2*N_BTN-1:N_BTN] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rel <= '0;
    else     rel <= (rel & ~rel_clr) | fall;
  end

  logic unused_bits;
  assign unused_bits = ^{addr[11:4], addr[1:0], wdata[31:2*N_BTN]};
`else
  logic unused_bits;
  assign unused_bits = ^{addr[11:4], addr[1:0], wdata[31:N_BTN], fall};
`endif

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_LEVEL: rdata[N_BTN-1:0] = stable;
      SEL_EVENT: begin
        rdata[N_BTN-1:0] = evt;
`ifdef BTN_RELEASE_EVT_EN
        rdata[2*N_BTN-1:N_BTN] = rel;
`endif
      end
      SEL_COUNT: rdata[15:0] = press_cnt;
      default:   rdata = '0;
    endcase
  end

  assign btn_stable = stable;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Bench for btn_input_ctrl: cycle-by-cycle vector table on a DEBOUNCE_CYCLES=4 instance,
// plus hand-written async-reset and counter-wrap sequences (wrap uses a DEBOUNCE_CYCLES=2 instance).
module tb_btn_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  button4;
  logic [4:0]  button2;
  logic [11:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata4;
  logic [31:0] rdata2;
  logic [4:0]  stable4;
  logic [4:0]  stable2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btn_input_ctrl #(.N_BTN(5), .CNT_W(20), .DEBOUNCE_CYCLES(4)) dut_d4 (
    .clk(clk), .rst(rst), .button(button4), .addr(addr), .wen(wen),
    .wdata(wdata), .rdata(rdata4), .btn_stable(stable4)
  );

  btn_input_ctrl #(.N_BTN(5), .CNT_W(20), .DEBOUNCE_CYCLES(2)) dut_d2 (
    .clk(clk), .rst(rst), .button(button2), .addr(addr), .wen(wen),
    .wdata(wdata), .rdata(rdata2), .btn_stable(stable2)
  );

  typedef struct {
    logic [4:0]  btn;
    logic [11:0] addr;
    logic        wen;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp_rd;
    logic [4:0]  exp_st;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [4:0] b, logic [11:0] a, logic w, logic [31:0] d,
                              bit c, logic [31:0] er, logic [4:0] es, string nm);
    vec_t v;
    v.btn = b; v.addr = a; v.wen = w; v.wdata = d;
    v.chk = c; v.exp_rd = er; v.exp_st = es; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Expected EVENT word for a given press/release flag set.
  function automatic logic [31:0] ev(logic [4:0] e, logic [4:0] r);
`ifdef BTN_RELEASE_EVT_EN
    return {22'b0, r, e};
`else
    return {27'b0, e} | (32'(r) & 32'h0);
`endif
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  initial begin
    // ---- reset release with 0x15 held ----
    for (int i = 0; i < 6; i++) add(5'h15, 12'(i % 4 * 4), 0, 0, 1, 0, 5'h00, "rst_hold");
    add(5'h15, 12'h000, 0, 0, 1, 32'h15, 5'h15, "rst_lvl");
    add(5'h15, 12'h004, 0, 0, 1, ev(5'h15, 0), 5'h15, "rst_evt");
    add(5'h15, 12'h008, 0, 0, 1, 32'd3, 5'h15, "rst_cnt");
    add(5'h15, 12'h00C, 0, 0, 1, 0, 5'h15, "rst_rsv");
    for (int i = 0; i < 6; i++) add(5'h00, 12'h000, 0, 0, 1, 32'h15, 5'h15, "rel_hold");
    add(0, 12'h000, 0, 0, 1, 0, 0, "rel_lvl");
    add(0, 12'h004, 0, 0, 1, ev(5'h15, 5'h15), 0, "evt_sticky");
    add(0, 12'h004, 1, 32'hFFFF_FFFF, 1, ev(5'h15, 5'h15), 0, "evt_w1c_pre");
    add(0, 12'h004, 0, 0, 1, 0, 0, "evt_w1c");
    add(0, 12'h008, 1, 0, 1, 32'd3, 0, "cnt_pre");
    add(0, 12'h008, 0, 0, 1, 0, 0, "cnt_clr");
    add(0, 12'h000, 1, 32'hFFFF_FFFF, 1, 0, 0, "lvl_wr");
    add(0, 12'h000, 0, 0, 1, 0, 0, "lvl_wr_ign");
    add(0, 12'h00C, 1, 32'hFFFF_FFFF, 1, 0, 0, "rsv_wr");
    add(0, 12'h004, 0, 0, 1, 0, 0, "rsv_wr_evt");
    add(0, 12'h008, 0, 0, 1, 0, 0, "rsv_wr_cnt");
    // ---- button[0] latency: stable rises on the 6th row after the first high sample ----
    for (int i = 0; i < 6; i++) add(5'h01, 12'h000, 0, 0, 1, 0, 0, "lat_pre");
    add(5'h01, 12'h000, 0, 0, 1, 32'h1, 5'h01, "lat_edge");
    add(5'h01, 12'h004, 0, 0, 1, ev(5'h01, 0), 5'h01, "lat_evt");
    add(5'h01, 12'h008, 0, 0, 1, 32'd1, 5'h01, "lat_cnt");
    add(5'h01, 12'h014, 0, 0, 1, ev(5'h01, 0), 5'h01, "addr_alias");
    for (int i = 0; i < 6; i++) add(5'h00, 12'h000, 0, 0, 1, 32'h1, 5'h01, "lat_rel_hold");
    add(0, 12'h000, 0, 0, 1, 0, 0, "lat_rel");
    add(0, 12'h004, 1, 32'h3FF, 1, ev(5'h01, 5'h01), 0, "fall_evt");
    add(0, 12'h004, 0, 0, 1, 0, 0, "evt_clr2");
    add(0, 12'h008, 1, 0, 1, 32'd1, 0, "cnt_pre2");
    add(0, 12'h008, 0, 0, 1, 0, 0, "cnt_clr2");
    // ---- glitches on button[1]: 3-cycle pulse, gap, 2-cycle pulse ----
    for (int i = 0; i < 3; i++)  add(5'h02, 12'h000, 0, 0, 1, 0, 0, "glitch");
    for (int i = 0; i < 6; i++)  add(5'h00, 12'h000, 0, 0, 1, 0, 0, "glitch");
    for (int i = 0; i < 2; i++)  add(5'h02, 12'h000, 0, 0, 1, 0, 0, "glitch");
    for (int i = 0; i < 10; i++) add(5'h00, 12'h000, 0, 0, 1, 0, 0, "glitch");
    add(0, 12'h004, 0, 0, 1, 0, 0, "glitch_evt");
    add(0, 12'h008, 0, 0, 1, 0, 0, "glitch_cnt");
    // ---- flags: evt=0x03, W1C 0x01, then W1C 0x02 racing a new button[1] press ----
    for (int i = 0; i < 6; i++) add(5'h03, 12'h000, 0, 0, 1, 0, 0, "two_pre");
    add(5'h03, 12'h000, 0, 0, 1, 32'h3, 5'h03, "two_lvl");
    add(5'h03, 12'h004, 0, 0, 1, ev(5'h03, 0), 5'h03, "two_evt");
    add(5'h03, 12'h008, 0, 0, 1, 32'd2, 5'h03, "two_cnt");
    add(5'h03, 12'h004, 1, 32'h1, 1, ev(5'h03, 0), 5'h03, "w1c_pre");
    add(5'h03, 12'h004, 0, 0, 1, ev(5'h02, 0), 5'h03, "w1c_one");
    for (int i = 0; i < 6; i++) add(5'h01, 12'h000, 0, 0, 1, 32'h3, 5'h03, "b1_rel_hold");
    add(5'h01, 12'h004, 0, 0, 1, ev(5'h02, 5'h02), 5'h01, "b1_rel");
    for (int i = 0; i < 5; i++) add(5'h03, 12'h004, 0, 0, 1, ev(5'h02, 5'h02), 5'h01, "b1_repress");
    add(5'h03, 12'h004, 1, 32'h2, 1, ev(5'h02, 5'h02), 5'h01, "setwin_pre");
    add(5'h03, 12'h004, 0, 0, 1, ev(5'h02, 5'h02), 5'h03, "setwin");
    add(5'h03, 12'h008, 0, 0, 1, 32'd3, 5'h03, "setwin_cnt");
    add(5'h03, 12'h004, 1, 32'h2, 1, ev(5'h02, 5'h02), 5'h03, "w1c_two_pre");
    add(5'h03, 12'h004, 0, 0, 1, ev(5'h00, 5'h02), 5'h03, "w1c_two");
    for (int i = 0; i < 6; i++) add(5'h00, 12'h000, 0, 0, 1, 32'h3, 5'h03, "all_rel_hold");
    add(0, 12'h000, 0, 0, 1, 0, 0, "all_rel");
    add(0, 12'h004, 1, 32'hFFFF_FFFF, 1, ev(5'h00, 5'h03), 0, "clr3_pre");
    add(0, 12'h004, 0, 0, 1, 0, 0, "clr3");
    add(0, 12'h008, 1, 0, 1, 32'd3, 0, "cnt_pre3");
    add(0, 12'h008, 0, 0, 1, 0, 0, "cnt_clr3");
    // ---- button[2] press and release, release-flag W1C ----
    for (int i = 0; i < 6; i++) add(5'h04, 12'h000, 0, 0, 1, 0, 0, "b2_pre");
    add(5'h04, 12'h000, 0, 0, 1, 32'h4, 5'h04, "b2_lvl");
    for (int i = 0; i < 6; i++) add(5'h00, 12'h000, 0, 0, 1, 32'h4, 5'h04, "b2_rel_hold");
    add(0, 12'h000, 0, 0, 1, 0, 0, "b2_rel");
    add(0, 12'h004, 0, 0, 1, ev(5'h04, 5'h04), 0, "rel_evt");
    add(0, 12'h004, 1, 32'h80, 1, ev(5'h04, 5'h04), 0, "rel_w1c_pre");
    add(0, 12'h004, 0, 0, 1, ev(5'h04, 5'h00), 0, "rel_w1c");
    add(0, 12'h008, 0, 0, 1, 32'd1, 0, "b2_cnt");

    // ---- reset asserted with 0x15 held ----
    rst = 1'b1; button4 = 5'h15; button2 = 5'h00; addr = '0; wen = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      addr = 12'(a * 4);
      #1;
      check($sformatf("in_rst_rd%0d", a), rdata4, 32'h0);
      check("in_rst_st", {27'b0, stable4}, 32'h0);
      @(negedge clk);
    end
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      button4 = vecs[i].btn;
      addr    = vecs[i].addr;
      wen     = vecs[i].wen;
      wdata   = vecs[i].wdata;
      #1;
      if (vecs[i].chk) begin
        check({vecs[i].name, "_rd"}, rdata4, vecs[i].exp_rd);
        check({vecs[i].name, "_st"}, {27'b0, stable4}, {27'b0, vecs[i].exp_st});
      end
    end
    @(negedge clk);
    wen = 1'b0; wdata = '0;

    // ---- async reset in the middle of a debounce count ----
    button4 = 5'h01; addr = 12'h008;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_cnt", rdata4, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      #1 check($sformatf("rst_restart_hold%0d", j), {27'b0, stable4}, 32'h0);
      @(negedge clk);
    end
    #1 check("rst_restart_rise", {27'b0, stable4}, 32'h1);
    @(negedge clk);
    button4 = 5'h00;
    repeat (8) @(negedge clk);

    // ---- press counter wrap: 13107 x 5 simultaneous presses = 65535 ----
    addr = 12'h008; wen = 1'b0;
    for (int n = 0; n < 13107; n++) begin
      button2 = 5'h1F;
      @(negedge clk);
      @(negedge clk);
      button2 = 5'h00;
      @(negedge clk);
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    #1 check("wrap_ffff", rdata2, 32'h0000_FFFF);
    check("wrap_st", {27'b0, stable2}, 32'h0);
    @(negedge clk);
    button2 = 5'h01;
    repeat (4) @(negedge clk);
    button2 = 5'h00;
    repeat (6) @(negedge clk);
    #1 check("wrap_zero", rdata2, 32'h0);
    @(negedge clk);
    button2 = 5'h02;
    repeat (4) @(negedge clk);
    button2 = 5'h00;
    repeat (6) @(negedge clk);
    #1 check("post_wrap", rdata2, 32'h1);

    // ---- COUNT write on the same edge two buttons become stable ----
    @(negedge clk);
    button2 = 5'h18;
    repeat (3) @(negedge clk);
    wen = 1'b1; wdata = 32'h0;
    #1 check("race_pre_st", {27'b0, stable2}, 32'h0);
    @(negedge clk);
    wen = 1'b0;
    #1 check("cnt_wr_race", rdata2, 32'h2);
    check("race_st", {27'b0, stable2}, 32'h18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_input_ctrl.md
Name: btn_input_ctrl

Overview:
- Bus-side input peripheral for the 5 push buttons; sits directly upstream of the Bridge button port and feeds it.
- Synchronises and debounces the raw buttons, then exposes three things as a 32-bit read word over the Bridge button interface:
  - the stable button level;
  - sticky press-event flags (write-1-to-clear);
  - a wrapping press counter.
- Replaces the raw zero-extended button wire currently feeding the Bridge.

Parameters:
- N_BTN, 5, number of buttons (1..8).
- CNT_W, 20, width of each per-button debounce counter.
- DEBOUNCE_CYCLES, 250000, consecutive clk cycles a new synchronised level must hold before it is accepted (10 ms at 25 MHz). Range 2..2^CNT_W-1.

Ports:
- clk, input, 1, CPU clock from the Bridge button clock output.
- rst, input, 1, asynchronous active-high reset.
- button, input, N_BTN, raw asynchronous button pins, active-high.
- addr, input, 12, byte offset within the button window; only addr[3:2] is decoded.
- wen, input, 1, bus write enable.
- wdata, input, 32, bus write data.
- rdata, output, 32, read data; combinational from addr and internal registers.
- btn_stable, output, N_BTN, debounced level for direct use by other logic.

Behaviour:
- Reset:
  - Synchronisers, stable levels, counters, event flags and the press counter all clear to 0.
  - Result: rdata = 0 for every addr, and btn_stable = 0.
  - Reset is asynchronous. An assertion mid-debounce discards any partial count.
- Synchronisation: two-flop synchroniser per button (s0, then s1). Only s1 is used downstream.
- Debounce, independently for each button i:
  - If s1[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= s1[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: a raw change sampled into s0 at edge k appears on stable at edge k+1+DEBOUNCE_CYCLES, provided the raw level holds throughout.
- Glitch rejection: any return of s1 to the stable value before acceptance resets the count, so no stable change occurs.
- Press event: stable[i] rising (0 to 1) sets evt[i] at the same edge. Falling edges set nothing.
- Press counter: 16-bit press_cnt increments by the number of buttons whose stable rises at that edge (popcount, 0..N_BTN). It wraps modulo 2^16 (0xFFFF+1 = 0x0000).
- Register map, selected by addr[3:2]:
  - 0 = LEVEL: read {zeros, stable}; writes ignored.
  - 1 = EVENT: read {zeros, evt}. On write, evt[i] clears where wdata[i]=1.
  - 2 = COUNT: read {16'b0, press_cnt}. Any write clears it to 0.
  - 3 = reserved: reads 0; writes ignored.
- Simultaneous events:
  - A new press and a W1C of the same evt bit at the same edge: set wins, so evt[i]=1.
  - A COUNT write and presses at the same edge: press_cnt <= number of presses at that edge.
- Reads have zero latency, with no side effects.
- Bits above N_BTN read 0.

Optional Feature:
- Macro BTN_RELEASE_EVT_EN.
- When defined:
  - stable falling edges set rel[i].
  - EVENT reads {zeros, rel, evt}, with rel at bits [2*N_BTN-1:N_BTN].
  - The W1C mask applies to both fields (wdata bits [2*N_BTN-1:N_BTN] clear rel).
  - Set-wins rule applies to rel as well.
- When undefined: no rel storage, and those EVENT bits read 0.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Reset with button=5'b10101 held: rdata=0 at all four offsets and btn_stable=0 until 2+4 cycles after release of rst; then LEVEL=0x15, EVENT=0x15, COUNT=3.
- Press button[0] sampled into s0 at edge k: btn_stable[0] rises exactly at edge k+5; EVENT=0x01 and COUNT=1 at that edge; LEVEL before the edge = 0.
- 3-cycle pulse on button[1], then a 2-cycle pulse on button[1] after an idle gap: LEVEL, EVENT and COUNT remain 0.
- Flag handling:
  - With evt=0x03, writing EVENT with wdata=0x01 gives evt=0x02.
  - Writing 0x02 at the same edge as a new button[1] press keeps evt=0x02.
- Preload press_cnt=0xFFFF via 65535 presses, with DEBOUNCE_CYCLES=2 to shorten the run; one more press gives COUNT=0x0000. A COUNT write concurrent with 2 simultaneous presses gives COUNT=2.
- With BTN_RELEASE_EVT_EN defined: press then release button[2] gives EVENT=0x0084; writing 0x80 gives EVENT=0x04. Without the macro, the same sequence gives EVENT=0x04.
